// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer: the sequencer state
// encoding and the width helper used to size the shared cycle counter.
package pll_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_e;

    // Bits needed to count up to the largest of three cycle limits (minimum one bit).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        if ($clog2(m) < 1) begin
            return 1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// Parameterized multi-flop synchronizer for a single asynchronous status bit.
// Cleared by a synchronous active-low reset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_chain <= {STAGES{1'b0}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a qualified lock and
// then releases the core reset; re-arms on timeout, lock loss or soft reset.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2,
    parameter int RETRY_W       = 4
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               soft_rst,
    output logic               pll_rst,
    output logic               sys_reset,
    output logic               ready,
    output logic [RETRY_W-1:0] retries
);

    localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_e             r_state;
    state_e             w_next_state;
    logic               w_timeout;
    logic               w_lk;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pll_rst;
    logic               r_sys_reset;
    logic               r_ready;
    logic [RETRY_W-1:0] r_retries;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk   (refclk),
        .i_rst_n (rst_n),
        .i_d     (pll_locked),
        .o_q     (w_lk)
    );

    // Next-state decode; soft reset overrides, and lock status wins over counter limits.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        if (soft_rst) begin
            w_next_state = PLL_RESET;
        end else begin
            case (r_state)
                PLL_RESET: begin
                    if (r_cnt == RST_LAST) begin
                        w_next_state = WAIT_LOCK;
                    end else begin
                        w_next_state = PLL_RESET;
                    end
                end
                WAIT_LOCK: begin
                    if (w_lk) begin
                        w_next_state = STABLE;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_next_state = PLL_RESET;
                        w_timeout    = 1'b1;
                    end else begin
                        w_next_state = WAIT_LOCK;
                    end
                end
                STABLE: begin
                    if (!w_lk) begin
                        w_next_state = WAIT_LOCK;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_next_state = RUN;
                    end else begin
                        w_next_state = STABLE;
                    end
                end
                RUN: begin
                    if (!w_lk) begin
                        w_next_state = WAIT_LOCK;
                    end else begin
                        w_next_state = RUN;
                    end
                end
                default: begin
                    w_next_state = PLL_RESET;
                end
            endcase
        end
    end

    // State, counter, retry count and next-state-decoded registered outputs.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_state     <= PLL_RESET;
            r_cnt       <= {CNT_W{1'b0}};
            r_pll_rst   <= 1'b1;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_retries   <= {RETRY_W{1'b0}};
        end else begin
            r_state     <= w_next_state;
            r_pll_rst   <= (w_next_state == PLL_RESET);
            r_sys_reset <= (w_next_state != RUN);
            r_ready     <= (w_next_state == RUN);
            // The counter holds in RUN so it can never wrap there.
            if (soft_rst || (w_next_state != r_state)) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_state != RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_timeout && (r_retries != {RETRY_W{1'b1}})) begin
                r_retries <= r_retries + RETRY_W'(1);
            end else begin
                r_retries <= r_retries;
            end
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_reset = r_sys_reset;
    assign ready     = r_ready;
    assign retries   = r_retries;

endmodule
